grf_dump: RTL
=============

GRF_DUMP -- requirements
Module: grf_dump

Interface
REQ-001 Parameter NREG, default 32, number of registers walked (addresses 0..NREG-1).
REQ-002 Parameter AW, default 5, register address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-005 start  input  1  request a full register dump; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 rd_addr  output  AW  address presented to the register-file read port.
REQ-008 rd_data  input  32  combinational read data returned for rd_addr in the same cycle.
REQ-009 out_valid  output  1  dump entry available on out_addr/out_data.
REQ-010 out_ready  input  1  downstream accepts the entry.
REQ-011 out_addr  output  AW  register number of the current entry.
REQ-012 out_data  output  32  register value of the current entry.
REQ-013 done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SEND, DONE, plus an AW-bit index counter idx.
REQ-015 IDLE: start=1 -> LOAD with idx=0; start=0 -> stay.
REQ-016 rd_addr SHALL equal idx combinationally in all states.
REQ-017 LOAD (one cycle): on the edge, out_data<=rd_data, out_addr<=idx, out_valid<=1, next state SEND.
REQ-018 When idx=0, out_data SHALL be captured as 32'h0 regardless of rd_data.
REQ-019 SEND: out_valid=1 AND out_ready=1 -> out_valid<=0; idx=NREG-1 -> DONE, else idx<=idx+1 -> LOAD.
REQ-020 SEND with out_ready=0: out_valid, out_addr and out_data SHALL hold unchanged, with no cap on stall length.
REQ-021 DONE (one cycle): done=1, then IDLE with idx<=0; done=0 in every other state.
REQ-022 Latency: start sampled at edge k -> out_valid high after edge k+1; with out_ready tied high, one entry every 2 cycles; done high in the cycle after edge k+2*NREG.
REQ-023 Entries SHALL be emitted in strictly ascending address order 0..NREG-1, each exactly once per dump; no entry dropped or duplicated.
REQ-024 start asserted in LOAD, SEND or DONE SHALL be ignored; it is neither queued nor restarts the walk.
REQ-025 Each register is read in its own LOAD cycle, so concurrent register-file writes are reflected if they land before that LOAD edge. The dump is live, not a snapshot.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, idx=0, busy=0, out_valid=0, out_addr=0, out_data=0, done=0, rd_addr=0.
REQ-028 Reset mid-dump SHALL abort the walk; after release, no entry is emitted until a new start.
REQ-029 Release of reset SHALL leave the block in IDLE; a start in the first post-release cycle SHALL be honoured.

Verification
REQ-030 Full dump, out_ready=1: register-file model reg[i]=32'hA000_0000+i, pulse start -> 32 entries, addr 0..31, data 0, A000_0001..A000_001F; done one cycle after last accept; total 64 cycles start-to-done.
REQ-031 Backpressure: out_ready=0 for 5 cycles at addr 7 -> out_addr=7 and out_data held stable all 5 cycles; one accept on release; next entry is addr 8.
REQ-032 Register 0: model drives rd_data=32'hFFFF_FFFF at addr 0 -> entry 0 data=32'h0.
REQ-033 Start while busy: second start pulse at addr 10 -> no restart; sequence continues 11..31; exactly one done pulse.
REQ-034 Reset mid-dump: reset=0 asynchronously at addr 15 -> out_valid and busy drop without a clock edge; after release with start=0, out_valid stays 0 for 10 cycles; new start -> dump restarts at addr 0.
REQ-035 Live read: model writes reg[20]=32'h1234_5678 while entry 5 is stalled -> entry 20 reports 32'h1234_5678.

Source files
------------

// File: rtl/grf_dump_if.sv
// Handshake bundle between the register-file dump walker and its requester/consumer.
// The slave side is the walker. The master side is the requester, register file and sink.
interface grf_dump_if #(
  parameter int AW = 5
);
  logic          start;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic          done;

  modport slave (
    input  start, rd_data, out_ready,
    output busy, rd_addr, out_valid, out_addr, out_data, done
  );

  modport master (
    output start, rd_data, out_ready,
    input  busy, rd_addr, out_valid, out_addr, out_data, done
  );
endinterface

// File: rtl/grf_dump.sv
// Walks registers 0..NREG-1 through a combinational read port.
// Each value is emitted as a valid/ready entry, then done pulses once.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture rd_data for idx into the output entry
// SEND  | entry valid, waiting for out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module grf_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  grf_dump_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic [31:0]   out_data_q;
  logic          done_q;
  logic [31:0]   out_data_d;

  // Register 0 is architecturally zero, whatever the register file returns.
  assign out_data_d = (idx_q == '0) ? 32'h0 : bus.rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= 32'h0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            idx_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          out_data_q  <= out_data_d;
          out_addr_q  <= idx_q;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_addr   = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;

endmodule
